logit_4_hw: RTL and testbench
=============================

LOGIT_4_HW -- requirements
Module: logit_4_hw

Interface
REQ-001 SHALL have parameter K, default 4, number of approximation segments.
REQ-002 SHALL have parameter DWIDTH, default 32, IEEE-754 single word width; only 32 is supported.
REQ-003 SHALL have parameter EXPONENT_WIDTH, default 8, exponent field width; only 8 is supported.
REQ-004 SHALL have parameter BIAS, default 8'd127, exponent bias.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request; accepted only in the cycle where ready=1.
REQ-008 SHALL have port x_in  input  DWIDTH  operand y, a probability in fp32.
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have port valid  output  1  one-cycle pulse marking y_out as the result.
REQ-011 SHALL have port y_out  output  DWIDTH  approximate logit(y) = ln(y/(1-y)) in fp32.

Function
REQ-012 SHALL implement the FSM states IDLE, CLASSIFY, SUB_ALIGN, SUB_NORM, LOOKUP and DONE.
REQ-013 SHALL, in IDLE with start=1, register x_in and go to CLASSIFY; with start=0 it SHALL stay in IDLE.
REQ-014 SHALL ignore start in all states except IDLE, with no effect on the operation in progress.
REQ-015 SHALL classify operands in CLASSIFY as follows:
- +0, -0 or subnormal -> -inf (0xFF800000).
- NaN, or negative nonzero normal -> 0x7FC00000.
- y>=1.0, including +inf -> +inf (0x7F800000).
- y==0.5 (0x3F000000) -> 0x00000000.
REQ-016 SHALL route special cases and 0.5<y<1 (exponent 126) from CLASSIFY to LOOKUP, and route 0<y<0.5 to SUB_ALIGN.
REQ-017 SHALL, in SUB_ALIGN, right-shift y's significand (hidden 1 included) by 127-exp, truncating shifted-out bits, then subtract it from 1.0's significand.
REQ-018 SHALL, in SUB_NORM, normalise the difference d:
- if the 1.0 bit is set, emit exponent 127 with mantissa 0;
- otherwise left-shift once and emit exponent 126.
- Exactly one cycle; no rounding.
REQ-019 SHALL, in LOOKUP, take m8 = the top 8 mantissa bits of the operand (y, or d for the lower branch) and select the magnitude:
- m8<64 -> 0.25 (0x3E800000).
- m8<160 -> 1.0 (0x3F800000).
- m8<232 -> 2.25 (0x40100000).
- otherwise -> 4.0 (0x40800000).
- d==1.0 (exponent 127) SHALL select 4.0.
REQ-020 SHALL set the result sign bit to 1 for the lower branch and 0 for the upper branch; special-case codes SHALL pass through unchanged.
REQ-021 SHALL register the result into y_out on leaving LOOKUP, assert valid for exactly the DONE cycle, then return to IDLE.
REQ-022 SHALL, on the upper and special paths, assert valid 3 cycles after the accepting edge.
REQ-023 SHALL, on the lower path, assert valid 5 cycles after the accepting edge.
REQ-024 SHALL hold y_out at its last result when valid=0.
REQ-025 SHALL support back-to-back requests: start may be reasserted in the IDLE cycle following DONE; the minimum request period is 4 cycles.

Reset
REQ-026 SHALL, while rst=1, force state=IDLE, valid=0, ready=1 and y_out=0x00000000, and clear the operand and sign registers.
REQ-027 SHALL, if rst is asserted mid-operation, abort the operation with no valid pulse; the first start after rst deasserts SHALL be accepted.
REQ-028 SHALL give rst priority over start when both are asserted in the same cycle.

Configuration
REQ-029 SHALL, when LOGIT_SAT_EN is defined, replace the +inf and -inf results with +8.0 (0x41000000) and -8.0 (0xC1000000); the NaN code SHALL be unchanged.
REQ-030 SHALL, when LOGIT_SAT_EN is undefined, output 0x7F800000 and 0xFF800000 for those cases; latency SHALL be identical in both builds.

Verification
REQ-031 SHALL cover: x_in=0x3F400000 (0.75) -> y_out=0x3F800000, valid exactly 3 cycles after acceptance, ready low for those 3 cycles.
REQ-032 SHALL cover: x_in=0x3E800000 (0.25) -> y_out=0xBF800000, valid 5 cycles after acceptance; x_in=0x30800000 (2^-30) -> y_out=0xC0800000 (d==1.0 case).
REQ-033 SHALL cover: 0x3F000000 -> 0x00000000; 0x3F800000 -> 0x7F800000 (0x41000000 with LOGIT_SAT_EN); 0x80000000 -> 0xFF800000 (0xC1000000 with LOGIT_SAT_EN); 0xBE99999A -> 0x7FC00000; 0x7FC00001 -> 0x7FC00000.
REQ-034 SHALL cover: start held high continuously with alternating 0.75/0.25 -> requests accepted only in IDLE cycles, results 0x3F800000 and 0xBF800000 in order, no extra valid pulses.
REQ-035 SHALL cover: rst pulsed during SUB_NORM of a 0.25 request -> no valid pulse, y_out=0, ready=1; a following 0.9 (0x3F666666) request -> 0x40100000 after 3 cycles.

Source files
------------

// File: rtl/logit_4_hw.sv
// logit_4_hw: multi-cycle, 4-segment piecewise approximation of ln(y/(1-y)) for fp32 y.
// Define LOGIT_SAT_EN to saturate the +/-inf results to +/-8.0.
module logit_4_hw #(
  parameter int          K              = 4,
  parameter int          DWIDTH         = 32,
  parameter int          EXPONENT_WIDTH = 8,
  parameter logic [7:0]  BIAS           = 8'd127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DWIDTH-1:0] x_in,
  output logic              ready,
  output logic              valid,
  output logic [DWIDTH-1:0] y_out
);

  localparam int MW    = DWIDTH - EXPONENT_WIDTH - 1;
  localparam int SEG_W = $clog2(K);

  localparam logic [DWIDTH-1:0] NAN_CODE  = 32'h7FC0_0000;
  localparam logic [DWIDTH-1:0] HALF_CODE = 32'h3F00_0000;
  localparam logic [DWIDTH-1:0] ZERO_CODE = 32'h0000_0000;
`ifdef LOGIT_SAT_EN
  localparam logic [DWIDTH-1:0] POS_CODE  = 32'h4100_0000;
  localparam logic [DWIDTH-1:0] NEG_CODE  = 32'hC100_0000;
`else
  localparam logic [DWIDTH-1:0] POS_CODE  = 32'h7F80_0000;
  localparam logic [DWIDTH-1:0] NEG_CODE  = 32'hFF80_0000;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLASSIFY  = 3'd1,
    SUB_ALIGN = 3'd2,
    SUB_NORM  = 3'd3,
    LOOKUP    = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t                  state_r;
  logic [DWIDTH-1:0]       op_r;
  logic                    sign_r;
  logic                    special_r;
  logic [MW:0]             diff_r;

  logic [EXPONENT_WIDTH-1:0] op_exp_s;
  logic [MW-1:0]             op_man_s;
  logic [MW-1:0]             norm_man_s;

  assign op_exp_s   = op_r[DWIDTH-2:MW];
  assign op_man_s   = op_r[MW-1:0];
  assign norm_man_s = MW'(diff_r << 1);

  // Segment index from the top 8 mantissa bits.
  function automatic logic [SEG_W-1:0] seg_of(input logic [7:0] m8);
    if (m8 < 8'd64)       seg_of = SEG_W'(0);
    else if (m8 < 8'd160) seg_of = SEG_W'(1);
    else if (m8 < 8'd232) seg_of = SEG_W'(2);
    else                  seg_of = SEG_W'(3);
  endfunction

  // Unsigned magnitude; exponent == BIAS only arises for d == 1.0.
  function automatic logic [DWIDTH-2:0] mag_of(input logic [EXPONENT_WIDTH-1:0] e,
                                               input logic [7:0] m8);
    if (e == BIAS) begin
      mag_of = 31'h4080_0000;
    end else begin
      case (seg_of(m8))
        SEG_W'(0): mag_of = 31'h3E80_0000;
        SEG_W'(1): mag_of = 31'h3F80_0000;
        SEG_W'(2): mag_of = 31'h4010_0000;
        default:   mag_of = 31'h4080_0000;
      endcase
    end
  endfunction

  // Control FSM with registered ready/valid/y_out and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= '0;
      sign_r    <= 1'b0;
      special_r <= 1'b0;
      diff_r    <= '0;
      ready     <= 1'b1;
      valid     <= 1'b0;
      y_out     <= ZERO_CODE;
    end else begin
      valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r      <= x_in;
            special_r <= 1'b0;
            ready     <= 1'b0;
            state_r   <= CLASSIFY;
          end else begin
            ready     <= 1'b1;
          end
        end
        CLASSIFY: begin
          // Order matters: zero/subnormal wins over the sign test.
          if (op_exp_s == '0) begin
            op_r      <= NEG_CODE;
            special_r <= 1'b1;
            state_r   <= LOOKUP;
          end else if (op_r[DWIDTH-1] || (op_exp_s == '1 && op_man_s != '0)) begin
            op_r      <= NAN_CODE;
            special_r <= 1'b1;
            state_r   <= LOOKUP;
          end else if (op_exp_s >= BIAS) begin
            op_r      <= POS_CODE;
            special_r <= 1'b1;
            state_r   <= LOOKUP;
          end else if (op_r == HALF_CODE) begin
            op_r      <= ZERO_CODE;
            special_r <= 1'b1;
            state_r   <= LOOKUP;
          end else if (op_exp_s == BIAS - 8'd1) begin
            sign_r    <= 1'b0;
            state_r   <= LOOKUP;
          end else begin
            sign_r    <= 1'b1;
            state_r   <= SUB_ALIGN;
          end
        end
        SUB_ALIGN: begin
          diff_r  <= {1'b1, {MW{1'b0}}} - ({1'b1, op_man_s} >> (BIAS - op_exp_s));
          state_r <= SUB_NORM;
        end
        SUB_NORM: begin
          if (diff_r[MW]) begin
            op_r <= {1'b0, BIAS, {MW{1'b0}}};
          end else begin
            op_r <= {1'b0, BIAS - 8'd1, norm_man_s};
          end
          state_r <= LOOKUP;
        end
        LOOKUP: begin
          if (special_r) begin
            y_out <= op_r;
          end else begin
            y_out <= {sign_r, mag_of(op_exp_s, op_man_s[MW-1:MW-8])};
          end
          valid   <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          ready   <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          ready   <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logit_4_hw.sv
// Self-checking bench for logit_4_hw: directed cases, random operands, back-to-back and reset abort.
module tb_logit_4_hw;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x_in;
  logic        ready;
  logic        valid;
  logic [31:0] y_out;

  int checks = 0;
  int errors = 0;

`ifdef LOGIT_SAT_EN
  localparam logic [31:0] POS_C = 32'h4100_0000;
  localparam logic [31:0] NEG_C = 32'hC100_0000;
`else
  localparam logic [31:0] POS_C = 32'h7F80_0000;
  localparam logic [31:0] NEG_C = 32'hFF80_0000;
`endif
  localparam logic [31:0] NAN_C = 32'h7FC0_0000;

  logit_4_hw dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x_in  (x_in),
    .ready (ready),
    .valid (valid),
    .y_out (y_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mag(input longint m8, input bit one);
    if (one)           return 32'h4080_0000;
    else if (m8 < 64)  return 32'h3E80_0000;
    else if (m8 < 160) return 32'h3F80_0000;
    else if (m8 < 232) return 32'h4010_0000;
    else               return 32'h4080_0000;
  endfunction

  // logit approximation straight from the arithmetic rules
  function automatic logic [31:0] ref_logit(input logic [31:0] x);
    longint e, man, sig, q, d, one;
    e   = longint'(x[30:23]);
    man = longint'(x[22:0]);
    one = longint'(1) << 23;
    if (e == 0) return NEG_C;
    if (x[31] == 1'b1 || (e == 255 && man != 0)) return NAN_C;
    if (e >= 127) return POS_C;
    if (x == 32'h3F00_0000) return 32'h0000_0000;
    if (e == 126) return ref_mag(man / 32768, 1'b0);
    sig = one + man;
    q   = (127 - e >= 40) ? 0 : sig / (longint'(1) << (127 - e));
    d   = one - q;
    if (d == one) return 32'h8000_0000 | ref_mag(0, 1'b1);
    return 32'h8000_0000 | ref_mag((2 * d - one) / 32768, 1'b0);
  endfunction

  function automatic int ref_lat(input logic [31:0] x);
    int e;
    e = int'(x[30:23]);
    if (x[31] == 1'b0 && e != 0 && e < 126) return 5;
    return 3;
  endfunction

  task automatic do_req(input logic [31:0] x, input string tag);
    logic [31:0] exp_y;
    int          n;
    bit          seen;
    exp_y = ref_logit(x);
    @(negedge clk);
    check_eq({tag, "_idle_ready"}, {31'd0, ready}, 32'd1);
    start = 1'b1;
    x_in  = x;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      start = 1'b0;
      x_in  = $urandom();
      n++;
      if (valid) seen = 1'b1;
      else check_eq({tag, "_busy_ready"}, {31'd0, ready}, 32'd0);
    end
    check_eq({tag, "_latency"}, seen ? n : 99, ref_lat(x));
    check_eq({tag, "_result"}, y_out, exp_y);
    check_eq({tag, "_done_ready"}, {31'd0, ready}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_valid_pulse"}, {31'd0, valid}, 32'd0);
    check_eq({tag, "_hold"}, y_out, exp_y);
    check_eq({tag, "_back_idle"}, {31'd0, ready}, 32'd1);
  endtask

  logic [31:0] directed [10] = '{32'h3F40_0000, 32'h3E80_0000, 32'h3080_0000, 32'h3F00_0000,
                                 32'h3F80_0000, 32'h8000_0000, 32'hBE99_999A, 32'h7FC0_0001,
                                 32'h7F80_0000, 32'h0000_0001};
  logic [31:0] specials [6] = '{32'h0000_0000, 32'h007F_FFFF, 32'h3F7F_FFFF, 32'h3F00_0001,
                                32'h3EFF_FFFF, 32'h0080_0000};

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_y;
    logic [31:0] xr;
    int          acc;
    int          vcnt;
    bit          pend;

    // reset with start asserted: reset must win
    rst   = 1'b1;
    start = 1'b1;
    x_in  = 32'h3F40_0000;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_yout", y_out, 32'd0);
    rst   = 1'b0;
    start = 1'b0;

    foreach (directed[i]) do_req(directed[i], $sformatf("dir%0d", i));
    foreach (specials[i]) do_req(specials[i], $sformatf("edge%0d", i));

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0:       xr = $urandom();
        1:       xr = {1'b0, 8'($urandom_range(90, 126)), 23'($urandom())};
        default: xr = {1'b0, 8'd126, 23'($urandom())};
      endcase
      do_req(xr, $sformatf("rnd%0d", i));
    end

    // start held high, alternating 0.75 / 0.25
    acc  = 0;
    pend = 1'b0;
    @(negedge clk);
    start = 1'b1;
    x_in  = 32'h3F40_0000;
    for (int i = 0; i < 70; i++) begin
      if (valid) begin
        if (q.size() == 0) check_eq("b2b_extra_valid", {31'd0, valid}, 32'd0);
        else begin
          exp_y = q.pop_front();
          check_eq("b2b_result", y_out, exp_y);
        end
      end
      if (i >= 60) start = 1'b0;
      if (ready && start) begin
        q.push_back(ref_logit(x_in));
        acc++;
        pend = 1'b1;
      end else if (pend) begin
        x_in = (x_in == 32'h3F40_0000) ? 32'h3E80_0000 : 32'h3F40_0000;
        pend = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("b2b_drain", q.size(), 32'd0);
    check_eq("b2b_accepts", acc, 32'd12);

    // reset during SUB_NORM of a 0.25 request
    start = 1'b1;
    x_in  = 32'h3E80_0000;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    vcnt = 0;
    repeat (8) begin
      if (valid) vcnt++;
      @(negedge clk);
    end
    check_eq("abort_no_valid", vcnt, 32'd0);
    check_eq("abort_yout", y_out, 32'd0);
    check_eq("abort_ready", {31'd0, ready}, 32'd1);
    do_req(32'h3F66_6666, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
